// File: rtl/dual_pkg.sv
// Shared defaults for the dual-port RAM: word width, address width and depth.
package dual_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

endpackage : dual_pkg

// File: rtl/dual_mem_core.sv
// Storage array with per-word valid bits, two write ports (port 1 wins on an address
// collision) and two asynchronous, valid-masked read ports showing pre-edge contents.
module dual_mem_core #(
    parameter int DATA_W = dual_pkg::DATA_W,
    parameter int ADDR_W = dual_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic              we2_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [DATA_W-1:0] rd1_data_o,
    output logic [DATA_W-1:0] rd2_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic wr1;
    logic wr2;

    // Port 2 drops its write when port 1 targets the same word in the same cycle.
    assign wr1 = we1_i;
    assign wr2 = we2_i && !(we1_i && (addr1_i == addr2_i));

    // NOTE: the data array has no reset; clearing 1024 words is not needed because
    // valid_q masks every word until it is written again after reset.
    always_ff @(posedge clk) begin
        if (wr1) begin
            mem_q[addr1_i] <= data1_i;
        end
        if (wr2) begin
            mem_q[addr2_i] <= data2_i;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which
    // is exactly what gives the read ports their read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (wr1) begin
                valid_q[addr1_i] <= 1'b1;
            end
            if (wr2) begin
                valid_q[addr2_i] <= 1'b1;
            end
        end
    end

    assign rd1_data_o = valid_q[addr1_i] ? mem_q[addr1_i] : '0;
    assign rd2_data_o = valid_q[addr2_i] ? mem_q[addr2_i] : '0;

endmodule : dual_mem_core

// File: rtl/dual.sv
// True dual-port RAM top: registered outputs, write-through on write cycles and
// read-first data from the shared core on read cycles.
module dual #(
    parameter int DATA_W = dual_pkg::DATA_W,
    parameter int ADDR_W = dual_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    output logic [DATA_W-1:0] out1,
    input  logic [DATA_W-1:0] data2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              we2,
    output logic [DATA_W-1:0] out2
);

    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic [DATA_W-1:0] out1_d;
    logic [DATA_W-1:0] out1_q;
    logic [DATA_W-1:0] out2_d;
    logic [DATA_W-1:0] out2_q;

    dual_mem_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .we1_i      (we1),
        .addr1_i    (addr1),
        .data1_i    (data1),
        .we2_i      (we2),
        .addr2_i    (addr2),
        .data2_i    (data2),
        .rd1_data_o (rd1_data),
        .rd2_data_o (rd2_data)
    );

    // A writing port echoes its own write data; a reading port sees pre-edge contents.
    always_comb begin
        out1_d = rd1_data;
        out2_d = rd2_data;
        if (we1) begin
            out1_d = data1;
        end
        if (we2) begin
            out2_d = data2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
        end
    end

    assign out1 = out1_q;
    assign out2 = out2_q;

endmodule : dual

// File: tb/tb_dual.sv
// Directed testbench for the dual-port RAM with hand-computed expected values.
module tb_dual;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] data1;
    logic [ADDR_W-1:0] addr1;
    logic              we1;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] data2;
    logic [ADDR_W-1:0] addr2;
    logic              we2;
    logic [DATA_W-1:0] out2;

    int n_checks = 0;
    int n_errors = 0;

    dual #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data1 (data1),
        .addr1 (addr1),
        .we1   (we1),
        .out1  (out1),
        .data2 (data2),
        .addr2 (addr2),
        .we2   (we2),
        .out2  (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive both ports, then advance to 1 time unit after the next rising edge.
    task automatic cycle(input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         input logic w2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
        we1   = w1;
        addr1 = a1;
        data1 = d1;
        we2   = w2;
        addr2 = a2;
        data2 = d2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        we1 = 1'b0; addr1 = '0; data1 = '0;
        we2 = 1'b0; addr2 = '0; data2 = '0;
        #2;
        check("reset_out1", out1, 16'h0000);
        check("reset_out2", out2, 16'h0000);

        // Writes during reset must be ignored and outputs must stay 0.
        cycle(1'b1, 10'd1, 16'hdead, 1'b1, 10'd2, 16'hbeef);
        check("rst_wr_out1", out1, 16'h0000);
        check("rst_wr_out2", out2, 16'h0000);
        rst_n = 1'b1;

        cycle(1'b0, 10'd0, 16'h0000, 1'b0, 10'd1023, 16'h0000);
        check("rd_empty_0", out1, 16'h0000);
        check("rd_empty_1023", out2, 16'h0000);
        cycle(1'b0, 10'd1, 16'h0000, 1'b0, 10'd2, 16'h0000);
        check("rd_rstwr_1", out1, 16'h0000);
        check("rd_rstwr_2", out2, 16'h0000);

        // Write-through on both ports.
        cycle(1'b1, 10'd1, 16'ha45a, 1'b1, 10'd2, 16'h1342);
        check("wt1_a", out1, 16'ha45a);
        check("wt2_a", out2, 16'h1342);
        cycle(1'b1, 10'd3, 16'hadff, 1'b1, 10'd4, 16'hcf22);
        check("wt1_b", out1, 16'hadff);
        check("wt2_b", out2, 16'hcf22);
        cycle(1'b1, 10'd5, 16'h1234, 1'b1, 10'd6, 16'h0000);
        check("wt1_c", out1, 16'h1234);
        check("wt2_c", out2, 16'h0000);

        cycle(1'b0, 10'd1, 16'h0000, 1'b0, 10'd2, 16'h0000);
        check("rd_1", out1, 16'ha45a);
        check("rd_2", out2, 16'h1342);
        cycle(1'b0, 10'd3, 16'h0000, 1'b0, 10'd4, 16'h0000);
        check("rd_3", out1, 16'hadff);
        check("rd_4", out2, 16'hcf22);

        // Mixed write/read, then overwrite of the same word.
        cycle(1'b1, 10'd7, 16'h5511, 1'b0, 10'd5, 16'h0000);
        check("mix_out1", out1, 16'h5511);
        check("mix_out2", out2, 16'h1234);
        cycle(1'b1, 10'd7, 16'h4545, 1'b0, 10'd5, 16'h0000);
        check("ovw_out1", out1, 16'h4545);
        cycle(1'b0, 10'd7, 16'h0000, 1'b0, 10'd7, 16'h0000);
        check("same_rd_out1", out1, 16'h4545);
        check("same_rd_out2", out2, 16'h4545);

        // Read-first: port 2 reads the word port 1 is overwriting.
        cycle(1'b1, 10'd1, 16'hffff, 1'b0, 10'd1, 16'h0000);
        check("rf_out1", out1, 16'hffff);
        check("rf_out2_old", out2, 16'ha45a);
        cycle(1'b0, 10'd1023, 16'h0000, 1'b0, 10'd1, 16'h0000);
        check("rf_out2_new", out2, 16'hffff);
        check("rd_empty_1023b", out1, 16'h0000);

        // Address range extremes.
        cycle(1'b1, 10'd1023, 16'hbeef, 1'b1, 10'd0, 16'h0f0f);
        cycle(1'b0, 10'd0, 16'h0000, 1'b0, 10'd1023, 16'h0000);
        check("edge_rd_0", out1, 16'h0f0f);
        check("edge_rd_1023", out2, 16'hbeef);

        // Write collision: port 1 wins in the array, each port echoes its own data.
        cycle(1'b1, 10'd9, 16'haaaa, 1'b1, 10'd9, 16'h5555);
        check("col_out1", out1, 16'haaaa);
        check("col_out2", out2, 16'h5555);
        cycle(1'b0, 10'd9, 16'h0000, 1'b0, 10'd9, 16'h0000);
        check("col_rd1", out1, 16'haaaa);
        check("col_rd2", out2, 16'haaaa);

        // Asynchronous reset mid-run, with a write attempted while held.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out1", out1, 16'h0000);
        check("async_out2", out2, 16'h0000);
        cycle(1'b1, 10'd2, 16'h7777, 1'b0, 10'd9, 16'h0000);
        check("held_out1", out1, 16'h0000);
        rst_n = 1'b1;
        cycle(1'b0, 10'd1, 16'h0000, 1'b0, 10'd2, 16'h0000);
        check("post_rst_rd1", out1, 16'h0000);
        check("post_rst_rd2", out2, 16'h0000);
        cycle(1'b0, 10'd9, 16'h0000, 1'b0, 10'd1023, 16'h0000);
        check("post_rst_rd9", out1, 16'h0000);
        check("post_rst_rd1023", out2, 16'h0000);

        // First edge after release accepts writes.
        cycle(1'b1, 10'd1, 16'h1111, 1'b0, 10'd1, 16'h0000);
        check("post_wr_out1", out1, 16'h1111);
        check("post_wr_out2", out2, 16'h0000);
        cycle(1'b0, 10'd1, 16'h0000, 1'b0, 10'd1, 16'h0000);
        check("post_rd_out1", out1, 16'h1111);
        check("post_rd_out2", out2, 16'h1111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dual

// File: doc/dual.md
DUAL -- requirements
Module: dual

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits, SHALL be supported.
REQ-002 Parameter ADDR_W, default 10, address width, SHALL be supported; depth SHALL be 2**ADDR_W (1024 words).
REQ-003 Port list SHALL be, clock and reset first:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data1  input  DATA_W  port-1 write data.
- addr1  input  ADDR_W  port-1 address.
- we1  input  1  port-1 write enable, active high.
- out1  output  DATA_W  port-1 registered read data.
- data2  input  DATA_W  port-2 write data.
- addr2  input  ADDR_W  port-2 address.
- we2  input  1  port-2 write enable, active high.
- out2  output  DATA_W  port-2 registered read data.
REQ-004 The design SHALL have one clock (clk) and one reset; rst_n SHALL be asynchronous and active-low.

Function
REQ-005 Storage SHALL be a 2**ADDR_W x DATA_W array shared by both ports, each port having independent read/write access every cycle.
REQ-006 With weN=1, mem[addrN] SHALL be written with dataN on the rising clk edge.
REQ-007 With weN=0, outN SHALL be loaded with mem[addrN] on the rising edge (1-cycle read latency).
REQ-008 With weN=1, outN SHALL be loaded with dataN on that edge (write-through).
REQ-009 outN SHALL update on every rising edge, never hold; no enable beyond weN exists.
REQ-010 Each word SHALL carry a valid bit; reading a word not written since reset SHALL return 0.
REQ-011 Both ports writing the same address in one cycle: port 1 SHALL win; mem gets data1; out1=data1, out2=data2.
REQ-012 One port reading an address the other writes in the same cycle SHALL return the old (pre-write) contents (read-first).
REQ-013 Both ports reading the same address SHALL both return identical data.
REQ-014 Addresses SHALL be used unmodified; full range 0..2**ADDR_W-1 valid, no wrap or out-of-range case.

Reset
REQ-015 While rst_n=0, out1 and out2 SHALL be 0 and all valid bits SHALL be cleared, asynchronously.
REQ-016 Array data contents need not be cleared; the valid bits SHALL mask them to 0.
REQ-017 Writes SHALL be ignored while rst_n=0; first write accepted on the first rising edge after rst_n rises.
REQ-018 Reset asserted mid-operation SHALL invalidate all prior writes.

Structure
REQ-019 Package dual_pkg SHALL hold DATA_W, ADDR_W and DEPTH defaults.
REQ-020 One sub-module, dual_mem_core (array plus valid bits, two write ports, port-1 priority), SHALL be instantiated by dual; output registers and read-first muxing live in dual.

Verification
REQ-021 Reset then read addr1=0, addr2=1023 with we=0 -> out1=0, out2=0 after one edge.
REQ-022 Write a45a@1 (p1) and 1342@2 (p2), adfe..: adff@3/cf22@4, 1234@5/0000@6 -> out1/out2 echo written data each cycle; later reads of 1,2,3,4 -> a45a, 1342, adff, cf22.
REQ-023 we1=1 data1=5511 addr1=7, we2=0 addr2=5 -> out1=5511, out2=1234 same edge; next cycle data1=4545@7 -> out1=4545; read 7 -> 4545.
REQ-024 Same cycle: p1 writes ffff@1, p2 reads 1 -> out2=a45a; next cycle p2 reads 1 -> ffff.
REQ-025 Both write address 9 (p1 aaaa, p2 5555) -> subsequent read of 9 returns aaaa.
REQ-026 Assert rst_n=0 asynchronously mid-run -> outputs 0 without clock edge; after release, read 1 -> 0.
